// File: rtl/mem_wb_unit_if.sv
// Bus bundle between execute stage, data memory and register-file write port
// of the memory/writeback unit.
interface mem_wb_unit_if;
   logic        ex_valid;
   logic        ex_wreg;
   logic [4:0]  ex_waddr;
   logic [31:0] ex_wdata;
   logic [3:0]  ex_memop;
   logic [31:0] ex_maddr;
   logic [31:0] ex_sdata;
   logic        stall_req;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        wb_we;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_wdata;
   logic        err;

   modport slave (
      input  ex_valid, ex_wreg, ex_waddr, ex_wdata,
      input  ex_memop, ex_maddr, ex_sdata,
      input  mem_ack, mem_rdata,
      output stall_req, mem_req, mem_we, mem_addr,
      output mem_be, mem_wdata,
      output wb_we, wb_waddr, wb_wdata, err
   );

   modport master (
      output ex_valid, ex_wreg, ex_waddr, ex_wdata,
      output ex_memop, ex_maddr, ex_sdata,
      output mem_ack, mem_rdata,
      input  stall_req, mem_req, mem_we, mem_addr,
      input  mem_be, mem_wdata,
      input  wb_we, wb_waddr, wb_wdata, err
   );
endinterface

// File: rtl/mem_wb_unit.sv
// Memory access + register writeback stage: one outstanding data access,
// alignment check, ack timeout, load lane extraction.
module mem_wb_unit #(
   parameter int unsigned TIMEOUT = 255
) (
   input logic          clk,
   input logic          rst,
   mem_wb_unit_if.slave bus
);
   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [7:0] LP_TMAX = 8'(TIMEOUT - 1);

   state_t      r_state, w_state_nx;
   logic [7:0]  r_cnt, w_cnt_nx;
   logic [3:0]  r_op, w_op_nx;
   logic [31:0] r_addr, w_addr_nx;
   logic [31:0] r_sdata, w_sdata_nx;
   logic [4:0]  r_waddr, w_waddr_nx;
   logic        r_wreg, w_wreg_nx;
   logic        r_wb_we, w_wb_we_nx;
   logic [4:0]  r_wb_waddr, w_wb_waddr_nx;
   logic [31:0] r_wb_wdata, w_wb_wdata_nx;
   logic        r_err, w_err_nx;

   logic        w_busy;
   logic        w_ex_mem;
   logic        w_mis;
   logic        w_store;
   logic        w_load;
   logic [31:0] w_sh;
   logic [31:0] w_ld;
   logic [3:0]  w_be;
   logic [31:0] w_wd;

   assign w_busy   = (r_state == BUSY);
   assign w_ex_mem = (bus.ex_memop >= 4'd1) &&
                     (bus.ex_memop <= 4'd8);
   assign w_store  = (r_op >= 4'd6) && (r_op <= 4'd8);
   assign w_load   = (r_op >= 4'd1) && (r_op <= 4'd5);
   assign w_sh     = bus.mem_rdata >> {r_addr[1:0], 3'b000};

   always_comb begin
      w_mis = 1'b0;
      case (bus.ex_memop)
         4'd2, 4'd5, 4'd7: w_mis = bus.ex_maddr[0];
         4'd3, 4'd8:       w_mis = |bus.ex_maddr[1:0];
         default:          w_mis = 1'b0;
      endcase
   end

   // Lane extraction; LH/LHU are halfword-aligned here so the shift is 0/16
   always_comb begin
      w_ld = 32'h0;
      case (r_op)
         4'd1:    w_ld = {{24{w_sh[7]}}, w_sh[7:0]};
         4'd2:    w_ld = {{16{w_sh[15]}}, w_sh[15:0]};
         4'd3:    w_ld = bus.mem_rdata;
         4'd4:    w_ld = {24'h0, w_sh[7:0]};
         4'd5:    w_ld = {16'h0, w_sh[15:0]};
         default: w_ld = 32'h0;
      endcase
   end

   always_comb begin
      w_be = 4'b1111;
      w_wd = 32'h0;
      case (r_op)
         4'd6: begin
            w_be = 4'b0001 << r_addr[1:0];
            w_wd = {4{r_sdata[7:0]}};
         end
         4'd7: begin
            w_be = r_addr[1] ? 4'b1100 : 4'b0011;
            w_wd = {2{r_sdata[15:0]}};
         end
         4'd8:    w_wd = r_sdata;
         default: w_be = 4'b1111;
      endcase
   end

   always_comb begin
      w_state_nx    = r_state;
      w_cnt_nx      = r_cnt;
      w_op_nx       = r_op;
      w_addr_nx     = r_addr;
      w_sdata_nx    = r_sdata;
      w_waddr_nx    = r_waddr;
      w_wreg_nx     = r_wreg;
      w_wb_we_nx    = 1'b0;
      w_wb_waddr_nx = r_wb_waddr;
      w_wb_wdata_nx = r_wb_wdata;
      w_err_nx      = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (bus.ex_valid) begin
               if (!w_ex_mem) begin
                  w_wb_we_nx    = bus.ex_wreg &&
                                  (bus.ex_waddr != 5'd0);
                  w_wb_waddr_nx = bus.ex_waddr;
                  w_wb_wdata_nx = bus.ex_wdata;
               end else if (w_mis) begin
                  w_err_nx = 1'b1;
               end else begin
                  w_state_nx = BUSY;
                  w_cnt_nx   = 8'd0;
                  w_op_nx    = bus.ex_memop;
                  w_addr_nx  = bus.ex_maddr;
                  w_sdata_nx = bus.ex_sdata;
                  w_waddr_nx = bus.ex_waddr;
                  w_wreg_nx  = bus.ex_wreg;
               end
            end
         end
         BUSY: begin
            // A late ack in the final allowed cycle still completes
            if (bus.mem_ack) begin
               w_state_nx = IDLE;
               if (w_load) begin
                  w_wb_we_nx    = r_wreg && (r_waddr != 5'd0);
                  w_wb_waddr_nx = r_waddr;
                  w_wb_wdata_nx = w_ld;
               end
            end else if (r_cnt == LP_TMAX) begin
               w_state_nx = IDLE;
               w_err_nx   = 1'b1;
            end else begin
               w_cnt_nx = r_cnt + 8'd1;
            end
         end
         default: w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= 8'd0;
         r_op       <= 4'd0;
         r_addr     <= 32'h0;
         r_sdata    <= 32'h0;
         r_waddr    <= 5'd0;
         r_wreg     <= 1'b0;
         r_wb_we    <= 1'b0;
         r_wb_waddr <= 5'd0;
         r_wb_wdata <= 32'h0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_cnt      <= w_cnt_nx;
         r_op       <= w_op_nx;
         r_addr     <= w_addr_nx;
         r_sdata    <= w_sdata_nx;
         r_waddr    <= w_waddr_nx;
         r_wreg     <= w_wreg_nx;
         r_wb_we    <= w_wb_we_nx;
         r_wb_waddr <= w_wb_waddr_nx;
         r_wb_wdata <= w_wb_wdata_nx;
         r_err      <= w_err_nx;
      end
   end

   assign bus.stall_req = w_busy;
   assign bus.mem_req   = w_busy;
   assign bus.mem_we    = w_busy && w_store;
   assign bus.mem_addr  = w_busy ? {r_addr[31:2], 2'b00} : 32'h0;
   assign bus.mem_be    = w_busy ? w_be : 4'b0000;
   assign bus.mem_wdata = w_busy ? w_wd : 32'h0;
   assign bus.wb_we     = r_wb_we;
   assign bus.wb_waddr  = r_wb_waddr;
   assign bus.wb_wdata  = r_wb_wdata;
   assign bus.err       = r_err;
endmodule

// File: tb/tb_mem_wb_unit.sv
// Bench for mem_wb_unit: vector table through a scoreboard queue plus
// hand sequences for reset, held input, idle ack and reset-in-busy.
module tb_mem_wb_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_run = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   mem_wb_unit_if bus();

   mem_wb_unit #(.TIMEOUT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [3:0]  op;
      logic        wreg;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [31:0] ma;
      logic [31:0] sd;
      logic [31:0] rd;
      int          dly;
      int          busy;
      logic        mwe;
      logic [3:0]  be;
      logic [31:0] mwd;
      logic        xwe;
      logic [31:0] xwd;
      logic        xerr;
   } vec_t;

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        err;
   } res_t;

   res_t sb[$];
   vec_t vt[16];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run(input vec_t v);
      res_t g;
      int   n;
      bus.ex_valid = 1'b1;
      bus.ex_wreg  = v.wreg;
      bus.ex_waddr = v.wa;
      bus.ex_wdata = v.wd;
      bus.ex_memop = v.op;
      bus.ex_maddr = v.ma;
      bus.ex_sdata = v.sd;
      sb.push_back('{v.xwe, v.wa, v.xwd, v.xerr});
      tick();
      bus.ex_valid = 1'b0;
      n = 0;
      while (bus.stall_req && n < 50) begin
         chk("mem_req", 32'(bus.mem_req), 32'd1);
         chk("mem_we", 32'(bus.mem_we), 32'(v.mwe));
         chk("mem_addr", bus.mem_addr, v.ma & 32'hFFFF_FFFC);
         chk("mem_be", 32'(bus.mem_be), 32'(v.be));
         chk("mem_wdata", bus.mem_wdata, v.mwd);
         chk("wb_we_busy", 32'(bus.wb_we), 32'd0);
         if (n == v.dly) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = v.rd;
         end
         tick();
         bus.mem_ack   = 1'b0;
         bus.mem_rdata = 32'h0;
         n++;
      end
      chk("busy_cycles", 32'(n), 32'(v.busy));
      chk("mem_req_done", 32'(bus.mem_req), 32'd0);
      g = sb.pop_front();
      chk("wb_we", 32'(bus.wb_we), 32'(g.we));
      if (g.we) begin
         chk("wb_waddr", 32'(bus.wb_waddr), 32'(g.wa));
         chk("wb_wdata", bus.wb_wdata, g.wd);
      end
      chk("err", 32'(bus.err), 32'(g.err));
      tick();
      chk("wb_pulse", 32'(bus.wb_we), 32'd0);
      chk("err_pulse", 32'(bus.err), 32'd0);
   endtask

   initial begin
      vt[0]  = '{4'd0, 1'b1, 5'd5, 32'h12345678, 32'h0, 32'h0, 32'h0, 0,
                 0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h12345678, 1'b0};
      vt[1]  = '{4'd1, 1'b1, 5'd3, 32'h0, 32'h103, 32'h0, 32'h80FF0011, 3,
                 4, 1'b0, 4'hF, 32'h0, 1'b1, 32'hFFFFFF80, 1'b0};
      vt[2]  = '{4'd7, 1'b1, 5'd2, 32'h0, 32'h202, 32'hAAAABEEF, 32'h0, 1,
                 2, 1'b1, 4'hC, 32'hBEEFBEEF, 1'b0, 32'h0, 1'b0};
      vt[3]  = '{4'd3, 1'b1, 5'd4, 32'h0, 32'h301, 32'h0, 32'h0, 0,
                 0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1};
      vt[4]  = '{4'd3, 1'b1, 5'd4, 32'h0, 32'h400, 32'h0, 32'h0, 255,
                 4, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0, 1'b1};
      vt[5]  = '{4'd3, 1'b1, 5'd0, 32'h0, 32'h10, 32'h0, 32'hDEADBEEF, 0,
                 1, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0};
      vt[6]  = '{4'd4, 1'b1, 5'd6, 32'h0, 32'h102, 32'h0, 32'h80FF0011, 0,
                 1, 1'b0, 4'hF, 32'h0, 1'b1, 32'h000000FF, 1'b0};
      vt[7]  = '{4'd2, 1'b1, 5'd7, 32'h0, 32'h102, 32'h0, 32'h80FF0011, 1,
                 2, 1'b0, 4'hF, 32'h0, 1'b1, 32'hFFFF80FF, 1'b0};
      vt[8]  = '{4'd5, 1'b1, 5'd8, 32'h0, 32'h100, 32'h0, 32'h1234F00D, 2,
                 3, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0000F00D, 1'b0};
      vt[9]  = '{4'd6, 1'b1, 5'd9, 32'h0, 32'h203, 32'h000000A5, 32'h0, 0,
                 1, 1'b1, 4'h8, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b0};
      vt[10] = '{4'd8, 1'b1, 5'd10, 32'h0, 32'h204, 32'hCAFEF00D, 32'h0, 0,
                 1, 1'b1, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0};
      vt[11] = '{4'd7, 1'b1, 5'd11, 32'h0, 32'h203, 32'h1234, 32'h0, 0,
                 0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1};
      vt[12] = '{4'd0, 1'b0, 5'd6, 32'h77, 32'h0, 32'h0, 32'h0, 0,
                 0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0};
      vt[13] = '{4'd0, 1'b1, 5'd0, 32'h88, 32'h0, 32'h0, 32'h0, 0,
                 0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0};
      vt[14] = '{4'd12, 1'b1, 5'd8, 32'h55, 32'h0, 32'h0, 32'h0, 0,
                 0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h55, 1'b0};
      vt[15] = '{4'd2, 1'b1, 5'd12, 32'h0, 32'h100, 32'h0, 32'h00007FFF, 0,
                 1, 1'b0, 4'hF, 32'h0, 1'b1, 32'h00007FFF, 1'b0};

      bus.ex_valid  = 1'b0;
      bus.ex_wreg   = 1'b0;
      bus.ex_waddr  = 5'd0;
      bus.ex_wdata  = 32'h0;
      bus.ex_memop  = 4'd0;
      bus.ex_maddr  = 32'h0;
      bus.ex_sdata  = 32'h0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'h0;

      repeat (3) tick();
      chk("rst_stall", 32'(bus.stall_req), 32'd0);
      chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
      chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'h0);
      chk("rst_wb_we", 32'(bus.wb_we), 32'd0);
      chk("rst_wb_wdata", bus.wb_wdata, 32'h0);
      chk("rst_err", 32'(bus.err), 32'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 16; i++) run(vt[i]);

      // ack while idle must be ignored
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hFFFF_FFFF;
      tick();
      bus.mem_ack = 1'b0;
      chk("idle_ack_stall", 32'(bus.stall_req), 32'd0);
      chk("idle_ack_wb", 32'(bus.wb_we), 32'd0);
      chk("idle_ack_req", 32'(bus.mem_req), 32'd0);

      // next instruction held during BUSY, accepted only once idle
      bus.ex_valid = 1'b1;
      bus.ex_wreg  = 1'b1;
      bus.ex_waddr = 5'd7;
      bus.ex_memop = 4'd3;
      bus.ex_maddr = 32'h20;
      tick();
      bus.ex_waddr = 5'd9;
      bus.ex_wdata = 32'h99;
      bus.ex_memop = 4'd0;
      chk("hold_stall", 32'(bus.stall_req), 32'd1);
      tick();
      chk("hold_still_busy", 32'(bus.stall_req), 32'd1);
      chk("hold_no_wb", 32'(bus.wb_we), 32'd0);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h11223344;
      tick();
      bus.mem_ack = 1'b0;
      chk("hold_ld_stall", 32'(bus.stall_req), 32'd0);
      chk("hold_ld_we", 32'(bus.wb_we), 32'd1);
      chk("hold_ld_wa", 32'(bus.wb_waddr), 32'd7);
      chk("hold_ld_wd", bus.wb_wdata, 32'h11223344);
      tick();
      bus.ex_valid = 1'b0;
      chk("hold_alu_we", 32'(bus.wb_we), 32'd1);
      chk("hold_alu_wa", 32'(bus.wb_waddr), 32'd9);
      chk("hold_alu_wd", bus.wb_wdata, 32'h99);
      tick();
      chk("hold_pulse", 32'(bus.wb_we), 32'd0);

      // reset while BUSY abandons the access silently
      bus.ex_valid = 1'b1;
      bus.ex_waddr = 5'd4;
      bus.ex_memop = 4'd3;
      bus.ex_maddr = 32'h30;
      tick();
      bus.ex_valid = 1'b0;
      chk("rb_req", 32'(bus.mem_req), 32'd1);
      rst = 1'b1;
      tick();
      chk("rb_req_off", 32'(bus.mem_req), 32'd0);
      chk("rb_stall", 32'(bus.stall_req), 32'd0);
      chk("rb_err", 32'(bus.err), 32'd0);
      chk("rb_wb", 32'(bus.wb_we), 32'd0);
      rst = 1'b0;
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      chk("rb_after_err", 32'(bus.err), 32'd0);
      chk("rb_after_wb", 32'(bus.wb_we), 32'd0);
      chk("rb_after_req", 32'(bus.mem_req), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
